// File: rtl/core_pkg.sv
// Shared types and constants for the instruction fetch unit.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x {rdata, pc} synchronous FIFO with a registered head,
// so the consumer never sees a combinational path from the write data.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output fetch_entry_t               head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_n, wr_ptr_n;
  logic [AW:0]    count_r, count_n, count_kept_s;
  logic           rd_en_s, wr_en_s;
  logic           head_valid_r;
  fetch_entry_t   head_data_r, head_n_s;

  // Next pointers/count and the entry that becomes the head after this edge.
  always_comb begin
    rd_en_s      = pop && (count_r != '0) && !flush;
    wr_en_s      = push && !flush && ((count_r != DEPTH_C) || rd_en_s);
    count_kept_s = count_r - (AW + 1)'(rd_en_s);
    if (flush) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else begin
      rd_ptr_n = rd_ptr_r + AW'(rd_en_s);
      wr_ptr_n = wr_ptr_r + AW'(wr_en_s);
      count_n  = count_kept_s + (AW + 1)'(wr_en_s);
    end
    if (count_n == '0) begin
      head_n_s = '0;
    end else if (count_kept_s == '0) begin
      head_n_s = push_data;
    end else begin
      head_n_s = mem_r[rd_ptr_n];
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      head_valid_r <= 1'b0;
      head_data_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      rd_ptr_r     <= rd_ptr_n;
      wr_ptr_r     <= wr_ptr_n;
      count_r      <= count_n;
      head_valid_r <= (count_n != '0);
      head_data_r  <= head_n_s;
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
      end
    end
  end

  assign full       = (count_r == DEPTH_C);
  assign empty      = (count_r == '0);
  assign count      = count_r;
  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, single-outstanding bus FSM, discard tracking
// for redirects, and the fetch buffer feeding decode.
module ifu
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req,
  input  logic        ibus_gnt,
  output logic [31:0] ibus_addr,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_rdata,
  output logic [31:0] fetch_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  fetch_state_t state_r, state_n;
  logic [31:0]  pc_r, pc_n, addr_r, addr_n, tgt_s;
  logic         discard_r, discard_n, redir_pend_r, redir_pend_n, req_r;
  logic         push_s, pop_s, full_s, empty_s, head_valid_s, space_s;
  logic [AW:0]  count_s, count_after_s;
  fetch_entry_t push_data_s, head_data_s;

  assign push_data_s = '{rdata: ibus_rdata, pc: addr_r};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .full       (full_s),
    .empty      (empty_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head_data  (head_data_s)
  );

  // FSM next state; redirect overrides everything. addr_r keeps the address of
  // the live request, pc_r the next address to fetch.
  always_comb begin
    state_n       = state_r;
    pc_n          = pc_r;
    addr_n        = addr_r;
    discard_n     = discard_r;
    redir_pend_n  = redir_pend_r;
    tgt_s         = align_word(redirect_pc);
    push_s        = (state_r == FETCH_WAIT) && ibus_rvalid && !discard_r && !redirect_valid;
    pop_s         = !empty_s && fetch_ready && !redirect_valid;
    count_after_s = count_s + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
    space_s       = (count_after_s < DEPTH_C);
    case (state_r)
      FETCH_IDLE: begin
        if (redirect_valid) begin
          pc_n    = tgt_s;
          addr_n  = tgt_s;
          state_n = FETCH_REQ;
        end else if (!full_s) begin
          addr_n  = pc_r;
          state_n = FETCH_REQ;
        end else begin
          state_n = FETCH_IDLE;
        end
      end
      FETCH_REQ: begin
        if (ibus_gnt) begin
          state_n = FETCH_WAIT;
          if (redirect_valid) begin
            discard_n    = 1'b1;
            redir_pend_n = 1'b0;
            pc_n         = tgt_s;
          end else if (redir_pend_r) begin
            discard_n    = 1'b1;
            redir_pend_n = 1'b0;
          end else begin
            pc_n = pc_r + 32'd4;
          end
        end else if (redirect_valid) begin
          pc_n         = tgt_s;
          redir_pend_n = 1'b1;
        end else begin
          state_n = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (ibus_rvalid) begin
          discard_n = 1'b0;
          if (redirect_valid) begin
            pc_n    = tgt_s;
            addr_n  = tgt_s;
            state_n = FETCH_REQ;
          end else if (space_s) begin
            addr_n  = pc_r;
            state_n = FETCH_REQ;
          end else begin
            state_n = FETCH_IDLE;
          end
        end else if (redirect_valid) begin
          discard_n = 1'b1;
          pc_n      = tgt_s;
        end else begin
          state_n = FETCH_WAIT;
        end
      end
      default: begin
        state_n = FETCH_IDLE;
      end
    endcase
  end

  // State registers; ibus_req is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH_IDLE;
      pc_r         <= RESET_PC;
      addr_r       <= RESET_PC;
      discard_r    <= 1'b0;
      redir_pend_r <= 1'b0;
      req_r        <= 1'b0;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      addr_r       <= addr_n;
      discard_r    <= discard_n;
      redir_pend_r <= redir_pend_n;
      req_r        <= (state_n == FETCH_REQ);
    end
  end

  assign ibus_req    = req_r;
  assign ibus_addr   = addr_r;
  assign fetch_valid = head_valid_s;
  assign fetch_rdata = head_data_s.rdata;
  assign fetch_pc    = head_data_s.pc;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a cycle-stepped memory model grants requests and
// returns words a programmable number of cycles later.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst, ibus_req, ibus_gnt, ibus_rvalid, redirect_valid, fetch_ready, fetch_valid;
  logic [31:0] ibus_addr, ibus_rdata, redirect_pc, fetch_rdata, fetch_pc;

  int          checks = 0;
  int          failures = 0;
  bit          auto_gnt, pend, rv_seen, granted;
  int          rv_lat, pend_cnt;
  logic [31:0] pend_addr, rv_addr;
  logic [31:0] gaddr[$];
  logic [63:0] popq[$];

  always #5 clk = ~clk;

  ifu #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req), .ibus_gnt(ibus_gnt), .ibus_addr(ibus_addr),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_rdata(fetch_rdata), .fetch_pc(fetch_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic cycle();
    @(negedge clk);
    if (fetch_valid && fetch_ready && !redirect_valid) popq.push_back({fetch_rdata, fetch_pc});
    ibus_rvalid = 1'b0;
    ibus_rdata  = 32'h0;
    rv_seen     = 1'b0;
    granted     = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend        = 1'b0;
        ibus_rvalid = 1'b1;
        ibus_rdata  = mem_word(pend_addr);
        rv_seen     = 1'b1;
        rv_addr     = pend_addr;
      end
    end
    ibus_gnt = auto_gnt && ibus_req;
    if (ibus_gnt) begin
      pend      = 1'b1;
      pend_cnt  = rv_lat;
      pend_addr = ibus_addr;
      granted   = 1'b1;
      gaddr.push_back(ibus_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; auto_gnt = 1'b0; rv_lat = 1; pend = 1'b0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    gaddr.delete(); popq.delete();
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    do begin cycle(); n++; end while (!granted && n < 10);
    checks++;
    if (!granted) begin failures++; $display("FAIL %s_grant_timeout got=none exp=grant", name); end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    cycle();
    checks++; if (ibus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", ibus_req); end
    checks++; if (ibus_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ibus_addr); end
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fvalid got=%0b exp=0", fetch_valid); end
    checks++; if (fetch_rdata !== 32'h0 || fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_fdata got=%h/%h exp=0/0", fetch_rdata, fetch_pc); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    auto_gnt = 1'b1; rv_lat = 1; fetch_ready = 1'b1;
    repeat (20) begin
      cycle();
      if (rv_seen) begin
        checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== rv_addr) begin
          failures++; $display("FAIL stream_latency got=%0b/%h exp=1/%h", fetch_valid, fetch_pc, rv_addr);
        end
      end
    end
    checks++; if (gaddr.size() != 10) begin failures++; $display("FAIL stream_throughput got=%0d exp=10", gaddr.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (gaddr.size() <= i || gaddr[i] !== 32'(4 * i)) begin
        failures++; $display("FAIL stream_addr idx=%0d exp=%h", i, 32'(4 * i));
      end
      checks++;
      if (popq.size() <= i || popq[i][31:0] !== 32'(4 * i) || popq[i][63:32] !== mem_word(32'(4 * i))) begin
        failures++; $display("FAIL stream_word idx=%0d exp_pc=%h exp_data=%h", i, 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    auto_gnt = 1'b1; rv_lat = 1; fetch_ready = 1'b0;
    repeat (10) cycle();
    checks++; if (gaddr.size() != 2) begin failures++; $display("FAIL bp_req_count got=%0d exp=2", gaddr.size()); end
    checks++; if (ibus_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle got=%0b exp=0", ibus_req); end
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) begin failures++; $display("FAIL bp_head got=%0b/%h exp=1/0", fetch_valid, fetch_pc); end
    gaddr.delete(); popq.delete();
    fetch_ready = 1'b1;
    cycle();
    fetch_ready = 1'b0;
    checks++; if (popq.size() != 1 || fetch_pc !== 32'h4) begin failures++; $display("FAIL bp_one_pop got=%0d/%h exp=1/4", popq.size(), fetch_pc); end
    repeat (8) cycle();
    checks++; if (gaddr.size() != 1 || gaddr[0] !== 32'h8) begin failures++; $display("FAIL bp_refill got=%0d reqs exp=1 at 8", gaddr.size()); end
    checks++; if (ibus_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle2 got=%0b exp=0", ibus_req); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    auto_gnt = 1'b1; rv_lat = 2; fetch_ready = 1'b1;
    wait_grant("rw");
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    gaddr.delete(); popq.delete();
    repeat (10) cycle();
    checks++; if (gaddr.size() < 1 || gaddr[0] !== 32'h100) begin failures++; $display("FAIL rw_next_addr exp=100 reqs=%0d", gaddr.size()); end
    checks++;
    if (popq.size() < 1 || popq[0][31:0] !== 32'h100 || popq[0][63:32] !== mem_word(32'h100)) begin
      failures++; $display("FAIL rw_first_word exp_pc=100 exp_data=%h pops=%0d", mem_word(32'h100), popq.size());
    end
  endtask

  task automatic test_redirect_req();
    do_reset();
    auto_gnt = 1'b0; rv_lat = 1; fetch_ready = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      redirect_valid = (k == 0);
      redirect_pc    = 32'h200;
      cycle();
      checks++;
      if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin
        failures++; $display("FAIL rq_hold k=%0d got=%0b/%h exp=1/0", k, ibus_req, ibus_addr);
      end
    end
    redirect_valid = 1'b0;
    auto_gnt = 1'b1;
    repeat (10) cycle();
    checks++; if (gaddr.size() < 2 || gaddr[0] !== 32'h0 || gaddr[1] !== 32'h200) begin failures++; $display("FAIL rq_addr_seq exp=0,200 reqs=%0d", gaddr.size()); end
    checks++; if (popq.size() < 1 || popq[0][31:0] !== 32'h200) begin failures++; $display("FAIL rq_first_pc exp=200 pops=%0d", popq.size()); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    auto_gnt = 1'b1; rv_lat = 1; fetch_ready = 1'b1;
    wait_grant("rv");
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rv_dropped got=%0b exp=0", fetch_valid); end
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin failures++; $display("FAIL rv_next_addr got=%0b/%h exp=1/200", ibus_req, ibus_addr); end
    gaddr.delete(); popq.delete();
    repeat (8) cycle();
    checks++;
    if (popq.size() < 1 || popq[0][31:0] !== 32'h200 || popq[0][63:32] !== mem_word(32'h200)) begin
      failures++; $display("FAIL rv_first_word exp_pc=200 pops=%0d", popq.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_gnt = 1'b1; rv_lat = 3; fetch_ready = 1'b1;
    wait_grant("rm");
    cycle();
    auto_gnt = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (ibus_req !== 1'b0 || ibus_addr !== 32'h0) begin failures++; $display("FAIL rm_bus got=%0b/%h exp=0/0", ibus_req, ibus_addr); end
    checks++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h0 || fetch_rdata !== 32'h0) begin failures++; $display("FAIL rm_fetch got=%0b/%h/%h exp=0/0/0", fetch_valid, fetch_pc, fetch_rdata); end
    gaddr.delete(); popq.delete();
    repeat (3) begin
      cycle();
      checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rm_late_rvalid got=%0b exp=0", fetch_valid); end
    end
    checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin failures++; $display("FAIL rm_restart got=%0b/%h exp=1/0", ibus_req, ibus_addr); end
    auto_gnt = 1'b1;
    repeat (6) cycle();
    checks++;
    if (popq.size() < 1 || popq[0][31:0] !== 32'h0 || popq[0][63:32] !== mem_word(32'h0)) begin
      failures++; $display("FAIL rm_first_word exp_pc=0 pops=%0d", popq.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_rvalid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
